// File: rtl/axi_cfg_slave.sv
// rtl/axi_cfg_slave.sv - AXI4 single-beat config register file driving accelerator cfg/start and capturing done
`timescale 1ns/1ps
module axi_cfg_slave #(
   parameter int AXI_ID_WIDTH = 6,
   parameter int AXIL_ADDR_WIDTH = 40,
   parameter int AXIL_WIDTH = 32,
   parameter int AXIL_STRB_WIDTH = AXIL_WIDTH/8,
   parameter logic [AXIL_ADDR_WIDTH-1:0] AXIL_BASE_ADDR = '0,
   parameter int N_REGS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
   input  logic [AXIL_ADDR_WIDTH-1:0]  s_axi_awaddr,
   input  logic [7:0]                  s_axi_awlen,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [AXIL_WIDTH-1:0]       s_axi_wdata,
   input  logic [AXIL_STRB_WIDTH-1:0]  s_axi_wstrb,
   input  logic                        s_axi_wlast,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
   input  logic [AXIL_ADDR_WIDTH-1:0]  s_axi_araddr,
   input  logic [7:0]                  s_axi_arlen,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
   output logic [AXIL_WIDTH-1:0]       s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rlast,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   output logic [(N_REGS-2)*32-1:0]    cfg,
   output logic                        start,
   input  logic                        done
);
   localparam int IDXW = $clog2(N_REGS);
   localparam logic [AXIL_ADDR_WIDTH-1:0] SPAN = AXIL_ADDR_WIDTH'(N_REGS*4);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic                       rdy_en;
   logic [AXIL_ADDR_WIDTH-1:0] aw_off, ar_off;
   logic                       aw_hit, ar_hit, aw_hit_q;
   logic [IDXW-1:0]            aw_idx, ar_idx;
   logic [7:0]                 aw_len, r_cnt;
   logic                       aw_fire, ar_fire, wr_en;
   logic [(N_REGS-2)*32-1:0]   cfg_q;
   logic                       start_q, busy, done_flag;
   logic [AXIL_WIDTH-1:0]      rd_word;

   // Address decode: aligned offset within the register window.
   assign aw_off = s_axi_awaddr - AXIL_BASE_ADDR;
   assign ar_off = s_axi_araddr - AXIL_BASE_ADDR;
   assign aw_hit = (s_axi_awaddr >= AXIL_BASE_ADDR) && (aw_off < SPAN) && (aw_off[1:0] == 2'b00);
   assign ar_hit = (s_axi_araddr >= AXIL_BASE_ADDR) && (ar_off < SPAN) && (ar_off[1:0] == 2'b00);
   assign ar_idx = ar_off[IDXW+1:2];

   assign aw_fire = s_axi_awready && s_axi_awvalid;
   assign ar_fire = s_axi_arready && s_axi_arvalid;
   assign wr_en   = (w_state == W_DATA) && s_axi_wvalid && (aw_len == 8'd0) && aw_hit_q;
   assign cfg     = cfg_q;
   assign start   = start_q;

   // Hold address readies low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdy_en <= 1'b0;
      else     rdy_en <= 1'b1;
   end

   // Write and read FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   // Write FSM next state and handshake outputs.
   always_comb begin
      w_next        = w_state;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (w_state)
         W_IDLE: begin
            s_axi_awready = rdy_en;
            if (rdy_en && s_axi_awvalid) w_next = W_DATA;
         end
         W_DATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid && ((aw_len == 8'd0) || s_axi_wlast)) w_next = W_RESP;
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Latch AW fields; response code is settled when the final W beat lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_axi_bid   <= '0;
         s_axi_bresp <= 2'b00;
         aw_len      <= 8'd0;
         aw_idx      <= '0;
         aw_hit_q    <= 1'b0;
      end else if (aw_fire) begin
         s_axi_bid <= s_axi_awid;
         aw_len    <= s_axi_awlen;
         aw_idx    <= aw_off[IDXW+1:2];
         aw_hit_q  <= aw_hit;
      end else if (w_state == W_DATA && s_axi_wvalid && (aw_len == 8'd0 || s_axi_wlast)) begin
         if (aw_len != 8'd0)  s_axi_bresp <= 2'b10;
         else if (aw_hit_q)   s_axi_bresp <= 2'b00;
         else                 s_axi_bresp <= 2'b11;
      end
   end

   // Register file, start pulse, busy tracking and sticky done flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q     <= '0;
         start_q   <= 1'b0;
         busy      <= 1'b0;
         done_flag <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (done) busy <= 1'b0;
         if (wr_en && aw_idx == IDXW'(0) && s_axi_wstrb[0] && s_axi_wdata[0] && !busy) begin
            start_q <= 1'b1;
            busy    <= 1'b1;
         end
         if (wr_en && aw_idx == IDXW'(1) && s_axi_wstrb[0] && s_axi_wdata[1]) done_flag <= 1'b0;
         if (done) done_flag <= 1'b1;
         for (int k = 2; k < N_REGS; k++)
            for (int b = 0; b < 4; b++)
               if (wr_en && aw_idx == IDXW'(k) && s_axi_wstrb[b])
                  cfg_q[(k-2)*32 + b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
   end

   // Read mux over the current register contents.
   always_comb begin
      rd_word = '0;
      if (ar_idx == IDXW'(1)) rd_word = {30'b0, done_flag, busy};
      for (int k = 2; k < N_REGS; k++)
         if (ar_idx == IDXW'(k)) rd_word = cfg_q[(k-2)*32 +: 32];
   end

   // Read FSM next state and handshake outputs.
   always_comb begin
      r_next        = r_state;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            s_axi_arready = rdy_en;
            if (rdy_en && s_axi_arvalid) r_next = R_DATA;
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // Read payload: captured on AR, bursts count down to the final beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_axi_rid   <= '0;
         s_axi_rdata <= '0;
         s_axi_rresp <= 2'b00;
         s_axi_rlast <= 1'b0;
         r_cnt       <= 8'd0;
      end else if (ar_fire) begin
         s_axi_rid <= s_axi_arid;
         r_cnt     <= s_axi_arlen;
         if (s_axi_arlen != 8'd0) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b10;
            s_axi_rlast <= 1'b0;
         end else if (ar_hit) begin
            s_axi_rdata <= rd_word;
            s_axi_rresp <= 2'b00;
            s_axi_rlast <= 1'b1;
         end else begin
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b11;
            s_axi_rlast <= 1'b1;
         end
      end else if (r_state == R_DATA && s_axi_rready && !s_axi_rlast) begin
         r_cnt       <= r_cnt - 8'd1;
         s_axi_rlast <= (r_cnt == 8'd1);
      end
   end
endmodule

// File: tb/tb_axi_cfg_slave.sv
// tb/tb_axi_cfg_slave.sv - directed self-checking bench for axi_cfg_slave
`timescale 1ns/1ps
module tb_axi_cfg_slave;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0]   awid, arid, bid, rid;
   logic [39:0]  awaddr, araddr;
   logic [7:0]   awlen, arlen;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rlast, rvalid, rready, start, done;
   logic [31:0]  wdata, rdata;
   logic [3:0]   wstrb;
   logic [1:0]   bresp, rresp;
   logic [191:0] cfg;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int start_cnt = 0;
   int start_cyc = -1;
   int last_w_cyc = 0;

   axi_cfg_slave dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .cfg(cfg), .start(start), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [39:0] addr, input logic [7:0] len, input logic [31:0] data,
                            input logic [3:0] strb, input logic [5:0] id, input int stall,
                            output logic [1:0] resp);
      int t;
      @(negedge clk);
      awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
      t = 0;
      while (!awready && t < 20) begin @(negedge clk); t++; end
      check("aw_wait", (t < 20), 1'b1);
      @(negedge clk);
      awvalid = 1'b0;
      check("wready_lat", wready, 1'b1);
      for (int i = 0; i <= int'(len); i++) begin
         wdata = data; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
         t = 0;
         while (!wready && t < 20) begin @(negedge clk); t++; end
         check("w_wait", (t < 20), 1'b1);
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      last_w_cyc = cyc;
      check("bvalid_lat", bvalid, 1'b1);
      resp = bresp;
      check("bid", bid, id);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("b_stall_valid", bvalid, 1'b1);
         check("b_stall_resp", bresp, resp);
         check("b_stall_id", bid, id);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      check("b_done", bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [39:0] addr, input logic [7:0] len, input logic [5:0] id,
                           input int stall, output logic [31:0] data, output logic [1:0] resp,
                           output logic last);
      int t;
      @(negedge clk);
      araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
      t = 0;
      while (!arready && t < 20) begin @(negedge clk); t++; end
      check("ar_wait", (t < 20), 1'b1);
      @(negedge clk);
      arvalid = 1'b0;
      check("rvalid_lat", rvalid, 1'b1);
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         while (!rvalid && t < 20) begin @(negedge clk); t++; end
         check("r_wait", (t < 20), 1'b1);
         check("rid", rid, id);
         check("rlast_beat", rlast, (i == int'(len)));
         if (len != 8'd0) begin
            check("burst_rdata", rdata, 32'h0);
            check("burst_rresp", rresp, 2'b10);
         end
         data = rdata; resp = rresp; last = rlast;
         if (i == 0) begin
            for (int s = 0; s < stall; s++) begin
               @(negedge clk);
               check("r_stall_valid", rvalid, 1'b1);
               check("r_stall_data", rdata, data);
               check("r_stall_resp", rresp, resp);
            end
         end
         rready = 1'b1;
         @(negedge clk);
         rready = 1'b0;
      end
      check("r_done", rvalid, 1'b0);
   endtask

   initial begin
      logic [1:0]   resp;
      logic [31:0]  rd;
      logic         lst;
      logic [191:0] exp_cfg;
      int           sc;
      awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0; done = 1'b0;
      exp_cfg = '0;

      repeat (3) @(negedge clk);
      check("rst_awready", awready, 1'b0);
      check("rst_arready", arready, 1'b0);
      check("rst_wready", wready, 1'b0);
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_cfg", cfg, exp_cfg);
      check("rst_start", start, 1'b0);
      rst = 1'b0;
      #1 check("awready_pre_edge", awready, 1'b0);
      @(negedge clk);
      check("awready_post_rst", awready, 1'b1);
      check("arready_post_rst", arready, 1'b1);

      // Full-word write and readback on reg 2
      axi_write(40'h8, 8'd0, 32'hDEADBEEF, 4'hF, 6'h15, 0, resp);
      check("wr8_bresp", resp, 2'b00);
      exp_cfg[31:0] = 32'hDEADBEEF;
      check("wr8_cfg", cfg, exp_cfg);
      axi_read(40'h8, 8'd0, 6'h2A, 0, rd, resp, lst);
      check("rd8_data", rd, 32'hDEADBEEF);
      check("rd8_resp", resp, 2'b00);
      check("rd8_last", lst, 1'b1);

      // Byte-strobe merge on reg 3
      axi_write(40'hC, 8'd0, 32'h11223344, 4'hF, 6'h01, 0, resp);
      axi_write(40'hC, 8'd0, 32'h0000AB00, 4'b0010, 6'h02, 0, resp);
      check("strb_bresp", resp, 2'b00);
      exp_cfg[63:32] = 32'h1122AB44;
      axi_read(40'hC, 8'd0, 6'h03, 0, rd, resp, lst);
      check("strb_rdata", rd, 32'h1122AB44);
      check("strb_cfg", cfg, exp_cfg);

      // CTRL start pulse, busy, done and W1C
      sc = start_cnt;
      axi_write(40'h0, 8'd0, 32'h1, 4'hF, 6'h04, 0, resp);
      check("start_cnt", start_cnt - sc, 1);
      check("start_cycle", start_cyc, last_w_cyc);
      check("start_low", start, 1'b0);
      axi_read(40'h4, 8'd0, 6'h05, 0, rd, resp, lst);
      check("status_busy", rd, 32'h1);
      sc = start_cnt;
      axi_write(40'h0, 8'd0, 32'h1, 4'hF, 6'h06, 0, resp);
      check("busy_write_bresp", resp, 2'b00);
      check("busy_no_start", start_cnt - sc, 0);
      @(negedge clk); done = 1'b1;
      @(negedge clk); done = 1'b0;
      axi_read(40'h4, 8'd0, 6'h07, 0, rd, resp, lst);
      check("status_done", rd, 32'h2);
      axi_write(40'h4, 8'd0, 32'h2, 4'hF, 6'h08, 0, resp);
      axi_read(40'h4, 8'd0, 6'h09, 0, rd, resp, lst);
      check("status_w1c", rd, 32'h0);
      axi_read(40'h0, 8'd0, 6'h0A, 0, rd, resp, lst);
      check("ctrl_reads0", rd, 32'h0);

      // Decode misses
      axi_read(40'h20, 8'd0, 6'h0B, 0, rd, resp, lst);
      check("miss_rresp", resp, 2'b11);
      check("miss_rdata", rd, 32'h0);
      axi_write(40'h2, 8'd0, 32'hFFFFFFFF, 4'hF, 6'h0C, 0, resp);
      check("miss_bresp", resp, 2'b11);
      check("miss_cfg", cfg, exp_cfg);

      // Bursts are drained and rejected
      axi_read(40'h8, 8'd3, 6'h0D, 0, rd, resp, lst);
      check("rburst_resp", resp, 2'b10);
      axi_write(40'h8, 8'd1, 32'h12345678, 4'hF, 6'h0E, 0, resp);
      check("wburst_bresp", resp, 2'b10);
      check("wburst_cfg", cfg, exp_cfg);

      // Backpressure on B and R
      axi_write(40'h10, 8'd0, 32'hCAFEF00D, 4'hF, 6'h3F, 5, resp);
      check("stall_bresp", resp, 2'b00);
      exp_cfg[95:64] = 32'hCAFEF00D;
      axi_read(40'h10, 8'd0, 6'h31, 5, rd, resp, lst);
      check("stall_rdata", rd, 32'hCAFEF00D);

      // Reset in the middle of a write data phase
      @(negedge clk);
      awaddr = 40'h14; awlen = 8'd0; awid = 6'h22; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      check("mid_wready", wready, 1'b1);
      rst = 1'b1;
      #1;
      exp_cfg = '0;
      check("mid_rst_wready", wready, 1'b0);
      check("mid_rst_awready", awready, 1'b0);
      check("mid_rst_arready", arready, 1'b0);
      check("mid_rst_bvalid", bvalid, 1'b0);
      check("mid_rst_bid", bid, 6'h0);
      check("mid_rst_cfg", cfg, exp_cfg);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rel_awready_pre", awready, 1'b0);
      @(negedge clk);
      check("rel_awready", awready, 1'b1);
      repeat (2) @(negedge clk);
      check("rel_no_b", bvalid, 1'b0);
      axi_read(40'hC, 8'd0, 6'h11, 0, rd, resp, lst);
      check("rel_rdata", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
